tlb_op_ctrl: RTL and testbench
==============================

// Module: tlb_op_ctrl
// PURPOSE
//  CP0-side sequencer for TLBP/TLBR/TLBWI/TLBWR; drives the TLB request/info interface and waits for tlb_done.
//  Writes probe/read results back to CP0 Index/EntryHi/EntryLo0/EntryLo1; owns the Random register.
//  Sits between the MEM-stage CP0 instruction decode and the TLB; stalls the pipeline while an op is in flight.
// PARAMETERS
//  TLBEntries  32  number of TLB entries
//  IDX_W       5   index width, = $clog2(TLBEntries)
// PORTS
//  clk             in   1      clock
//  rst             in   1      asynchronous reset, active-high
//  op_valid        in   1      TLB instruction presented
//  op_code         in   2      00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
//  op_ready        out  1      controller idle; op accepted when op_valid & op_ready
//  op_done         out  1      one-cycle completion pulse
//  op_err          out  1      one-cycle watchdog abort pulse (TLB_OP_WATCHDOG_EN only, else tied 0)
//  flush           in   1      exception/flush: abandon in-flight op
//  cp0_index       in   IDX_W  CP0 Index[IDX_W-1:0]
//  cp0_entryhi     in   32     CP0 EntryHi (VPN2 [31:13], ASID [7:0])
//  cp0_entrylo0    in   32     CP0 EntryLo0
//  cp0_entrylo1    in   32     CP0 EntryLo1
//  cp0_wired       in   IDX_W  CP0 Wired
//  cp0_wired_we    in   1      Wired being written this cycle
//  random          out  IDX_W  CP0 Random value
//  tlb_req         out  3      0 NONE, 1 TLBP, 2 TLBR, 3 TLBWI, 4 TLBWR
//  tlb_index       out  IDX_W  entry index for TLBR/TLBWI/TLBWR
//  tlb_entryhi     out  32     latched EntryHi
//  tlb_entrylo0    out  32     latched EntryLo0
//  tlb_entrylo1    out  32     latched EntryLo1
//  tlb_done        in   1      TLB finished the current request; results valid this cycle
//  tlb_probe_hit   in   1      TLBP matched
//  tlb_probe_idx   in   IDX_W  matching entry
//  tlb_res_entryhi in   32     TLBR result (likewise res_entrylo0/res_entrylo1, 32 each)
//  wb_index_we     out  1      write CP0 Index with wb_index
//  wb_index        out  32     {P, 31-IDX_W zeros, idx}
//  wb_tlb_we       out  1      write CP0 EntryHi/EntryLo0/EntryLo1 with wb_entryhi/wb_entrylo0/wb_entrylo1 (out, 32 each)
// BEHAVIOUR
//  Reset: state IDLE; op_ready=1; random=TLBEntries-1; all other outputs 0.
//  FSM IDLE -> REQ -> WB -> IDLE.
//   IDLE: on accept, latch cp0_* into tlb_* regs.
//     Index = cp0_index for TLBR/TLBWI; Index = current random for TLBWR.
//     If TLBR/TLBWI and cp0_index >= TLBEntries: go to WB with no TLB request (op_done only, no CP0 write).
//   REQ: tlb_req = op encoding, held stable until tlb_done sampled 1. Capture results, then go to WB.
//   WB (1 cycle): op_done=1.
//     TLBP: wb_index_we=1; hit -> wb_index={1'b0,...,tlb_probe_idx}; miss -> 32'h8000_0000.
//     TLBR: wb_tlb_we=1 with captured results.
//     TLBWI/TLBWR: no CP0 writeback.
//  op_ready=1 only in IDLE. op_valid while busy is ignored. Minimum latency: accept -> op_done = 2 cycles.
//  tlb_req=NONE in IDLE and WB. tlb_done outside REQ is ignored.
//  flush in REQ: next state IDLE, tlb_req drops to NONE, no op_done/writeback.
//  flush in IDLE or WB: no effect; the WB pulse still fires.
//  Random: decrements every cycle. At value == cp0_wired (or below it) it wraps to TLBEntries-1 next cycle.
//    If cp0_wired >= TLBEntries-1, Random holds TLBEntries-1.
//    cp0_wired_we forces TLBEntries-1 and has priority over the decrement.
//  Async rst mid-op: immediate return to reset state; in-flight op dropped.
// CONFIGURATION
//  TLB_OP_WATCHDOG_EN defined: 4-bit counter runs in REQ. After 15 cycles in REQ without tlb_done,
//    go to IDLE, pulse op_err, no op_done/writeback. Counter clears on entry to REQ.
//  Undefined: REQ waits indefinitely; op_err tied 0.
// TESTING
//  TLBP, tlb_done 1 cycle after REQ, hit idx 7 -> wb_index=32'h0000_0007, op_done 2 cycles after accept.
//  TLBP miss -> wb_index=32'h8000_0000, wb_tlb_we=0.
//  TLBR index 3, res_entryhi=32'h1234_6001 -> wb_tlb_we=1, wb_entryhi=32'h1234_6001. Same op with index 40 -> op_done, no tlb_req, no writes.
//  cp0_wired=4, free-run -> random sequence 31..4,31. cp0_wired_we -> 31 next cycle. TLBWR uses tlb_index = random at accept.
//  TLBWI with flush in 2nd REQ cycle -> tlb_req=0 next cycle, no op_done; op_ready=1.
//  TLB_OP_WATCHDOG_EN defined, tlb_done never asserted -> op_err pulse after 15 REQ cycles, op_ready returns to 1.

Source files
------------

// File: rtl/tlb_op_ctrl.sv
// CP0-side TLB instruction sequencer (TLBP/TLBR/TLBWI/TLBWR) that also owns the Random register.
// Optional REQ-state watchdog enabled by defining TLB_OP_WATCHDOG_EN.
module tlb_op_ctrl #(
  parameter int unsigned TLBEntries = 32,
  parameter int unsigned IDX_W      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [1:0]        op_code,
  output logic              op_ready,
  output logic              op_done,
  output logic              op_err,
  input  logic              flush,
  input  logic [IDX_W-1:0]  cp0_index,
  input  logic [31:0]       cp0_entryhi,
  input  logic [31:0]       cp0_entrylo0,
  input  logic [31:0]       cp0_entrylo1,
  input  logic [IDX_W-1:0]  cp0_wired,
  input  logic              cp0_wired_we,
  output logic [IDX_W-1:0]  random,
  output logic [2:0]        tlb_req,
  output logic [IDX_W-1:0]  tlb_index,
  output logic [31:0]       tlb_entryhi,
  output logic [31:0]       tlb_entrylo0,
  output logic [31:0]       tlb_entrylo1,
  input  logic              tlb_done,
  input  logic              tlb_probe_hit,
  input  logic [IDX_W-1:0]  tlb_probe_idx,
  input  logic [31:0]       tlb_res_entryhi,
  input  logic [31:0]       tlb_res_entrylo0,
  input  logic [31:0]       tlb_res_entrylo1,
  output logic              wb_index_we,
  output logic [31:0]       wb_index,
  output logic              wb_tlb_we,
  output logic [31:0]       wb_entryhi,
  output logic [31:0]       wb_entrylo0,
  output logic [31:0]       wb_entrylo1
);

  localparam logic [IDX_W-1:0] RandMax = IDX_W'(TLBEntries - 1);

  localparam logic [1:0] OpTlbp  = 2'b00;
  localparam logic [1:0] OpTlbr  = 2'b01;
  localparam logic [1:0] OpTlbwi = 2'b10;
  localparam logic [1:0] OpTlbwr = 2'b11;

  typedef enum logic [1:0] {StIdle, StReq, StWb} state_e;

  state_e           state;
  logic [1:0]       op_q;
  logic [IDX_W-1:0] random_d;
  logic             idx_bad;
  logic             uses_index;

`ifdef TLB_OP_WATCHDOG_EN
  logic [3:0]       wd_cnt;
`endif

  // Index may be wider than log2(TLBEntries), so out-of-range is a real compare.
  assign idx_bad    = 32'(cp0_index) >= TLBEntries;
  assign uses_index = (op_code == OpTlbr) || (op_code == OpTlbwi);

  always_comb begin
    random_d = random - 1'b1;
    if (cp0_wired_we || (cp0_wired >= RandMax) || (random <= cp0_wired)) begin
      random_d = RandMax;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      random <= RandMax;
    end else begin
      random <= random_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      op_q         <= OpTlbp;
      op_ready     <= 1'b1;
      op_done      <= 1'b0;
      tlb_req      <= 3'd0;
      tlb_index    <= '0;
      tlb_entryhi  <= '0;
      tlb_entrylo0 <= '0;
      tlb_entrylo1 <= '0;
      wb_index_we  <= 1'b0;
      wb_index     <= '0;
      wb_tlb_we    <= 1'b0;
      wb_entryhi   <= '0;
      wb_entrylo0  <= '0;
      wb_entrylo1  <= '0;
`ifdef TLB_OP_WATCHDOG_EN
      op_err       <= 1'b0;
      wd_cnt       <= '0;
`endif
    end else begin
      op_done     <= 1'b0;
      wb_index_we <= 1'b0;
      wb_tlb_we   <= 1'b0;
`ifdef TLB_OP_WATCHDOG_EN
      op_err      <= 1'b0;
`endif
      unique case (state)
        StIdle: begin
          if (op_valid) begin
            op_q         <= op_code;
            op_ready     <= 1'b0;
            tlb_entryhi  <= cp0_entryhi;
            tlb_entrylo0 <= cp0_entrylo0;
            tlb_entrylo1 <= cp0_entrylo1;
            tlb_index    <= (op_code == OpTlbwr) ? random : cp0_index;
            if (uses_index && idx_bad) begin
              // Bad index: complete without touching the TLB or CP0.
              state   <= StWb;
              op_done <= 1'b1;
            end else begin
              state   <= StReq;
              tlb_req <= {1'b0, op_code} + 3'd1;
`ifdef TLB_OP_WATCHDOG_EN
              wd_cnt  <= '0;
`endif
            end
          end
        end
        StReq: begin
          if (flush) begin
            state    <= StIdle;
            tlb_req  <= 3'd0;
            op_ready <= 1'b1;
          end else if (tlb_done) begin
            state   <= StWb;
            tlb_req <= 3'd0;
            op_done <= 1'b1;
            if (op_q == OpTlbp) begin
              wb_index_we <= 1'b1;
              wb_index    <= {~tlb_probe_hit, {(31 - IDX_W){1'b0}},
                              tlb_probe_hit ? tlb_probe_idx : {IDX_W{1'b0}}};
            end else if (op_q == OpTlbr) begin
              wb_tlb_we   <= 1'b1;
              wb_entryhi  <= tlb_res_entryhi;
              wb_entrylo0 <= tlb_res_entrylo0;
              wb_entrylo1 <= tlb_res_entrylo1;
            end
          end
`ifdef TLB_OP_WATCHDOG_EN
          // 15th REQ cycle without tlb_done aborts the op.
          else if (wd_cnt == 4'd14) begin
            state    <= StIdle;
            tlb_req  <= 3'd0;
            op_ready <= 1'b1;
            op_err   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 4'd1;
          end
`endif
        end
        StWb: begin
          state    <= StIdle;
          op_ready <= 1'b1;
        end
        default: begin
          state    <= StIdle;
          tlb_req  <= 3'd0;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

`ifndef TLB_OP_WATCHDOG_EN
  assign op_err = 1'b0;
`endif

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: vector table of single ops plus hand-written
// sequences for Random, flush, async reset and (when enabled) the watchdog.
module tb_tlb_op_ctrl;

  localparam int unsigned Ent = 32;
  localparam int unsigned IW  = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          op_valid = 1'b0;
  logic [1:0]    op_code = 2'b00;
  logic          op_ready, op_done, op_err;
  logic          flush = 1'b0;
  logic [IW-1:0] cp0_index = '0;
  logic [31:0]   cp0_entryhi = '0, cp0_entrylo0 = '0, cp0_entrylo1 = '0;
  logic [IW-1:0] cp0_wired = 6'd31;
  logic          cp0_wired_we = 1'b0;
  logic [IW-1:0] random;
  logic [2:0]    tlb_req;
  logic [IW-1:0] tlb_index;
  logic [31:0]   tlb_entryhi, tlb_entrylo0, tlb_entrylo1;
  logic          tlb_done = 1'b0;
  logic          tlb_probe_hit = 1'b0;
  logic [IW-1:0] tlb_probe_idx = '0;
  logic [31:0]   tlb_res_entryhi = '0, tlb_res_entrylo0 = '0, tlb_res_entrylo1 = '0;
  logic          wb_index_we, wb_tlb_we;
  logic [31:0]   wb_index, wb_entryhi, wb_entrylo0, wb_entrylo1;

  int n_vec = 0;
  int n_err = 0;

  tlb_op_ctrl #(.TLBEntries(Ent), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .op_done(op_done), .op_err(op_err), .flush(flush), .cp0_index(cp0_index),
    .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
    .cp0_wired(cp0_wired), .cp0_wired_we(cp0_wired_we), .random(random), .tlb_req(tlb_req),
    .tlb_index(tlb_index), .tlb_entryhi(tlb_entryhi), .tlb_entrylo0(tlb_entrylo0),
    .tlb_entrylo1(tlb_entrylo1), .tlb_done(tlb_done), .tlb_probe_hit(tlb_probe_hit),
    .tlb_probe_idx(tlb_probe_idx), .tlb_res_entryhi(tlb_res_entryhi),
    .tlb_res_entrylo0(tlb_res_entrylo0), .tlb_res_entrylo1(tlb_res_entrylo1),
    .wb_index_we(wb_index_we), .wb_index(wb_index), .wb_tlb_we(wb_tlb_we),
    .wb_entryhi(wb_entryhi), .wb_entrylo0(wb_entrylo0), .wb_entrylo1(wb_entrylo1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish before 200us");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [IW-1:0] idx;
    int            delay;
    logic          hit;
    logic [IW-1:0] pidx;
    logic [31:0]   hi;
    logic [31:0]   res_hi;
    logic          bad;
    logic [2:0]    exp_req;
    logic          exp_iwe;
    logic [31:0]   exp_widx;
    logic          exp_twe;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk("ready_before", op_ready, 1);
    op_valid = 1'b1; op_code = v.op; cp0_index = v.idx;
    cp0_entryhi = v.hi; cp0_entrylo0 = ~v.hi; cp0_entrylo1 = v.hi + 32'd4;
    tlb_probe_hit = v.hit; tlb_probe_idx = v.pidx;
    tlb_res_entryhi = v.res_hi; tlb_res_entrylo0 = v.res_hi ^ 32'hffff_0000;
    tlb_res_entrylo1 = v.res_hi + 32'd1;
    @(negedge clk);
    op_valid = 1'b0;
    if (v.bad) begin
      chk("bad_req", tlb_req, 0);
      chk("bad_done", op_done, 1);
      chk("bad_we", {wb_index_we, wb_tlb_we}, 0);
    end else begin
      chk("req", tlb_req, v.exp_req);
      chk("req_ready", op_ready, 0);
      chk("tlb_entryhi", tlb_entryhi, v.hi);
      chk("tlb_entrylo0", tlb_entrylo0, ~v.hi);
      if (v.op == 2'b01 || v.op == 2'b10) chk("tlb_index", tlb_index, 32'(v.idx));
      for (int i = 0; i < v.delay; i++) begin
        @(negedge clk);
        chk("req_hold", {tlb_req, op_done}, {v.exp_req, 1'b0});
      end
      tlb_done = 1'b1;
      @(negedge clk);
      tlb_done = 1'b0;
      chk("done", op_done, 1);
      chk("wb_req", tlb_req, 0);
      chk("index_we", wb_index_we, v.exp_iwe);
      if (v.exp_iwe) chk("wb_index", wb_index, v.exp_widx);
      chk("tlb_we", wb_tlb_we, v.exp_twe);
      if (v.exp_twe) begin
        chk("wb_entryhi", wb_entryhi, v.res_hi);
        chk("wb_entrylo0", wb_entrylo0, v.res_hi ^ 32'hffff_0000);
        chk("wb_entrylo1", wb_entrylo1, v.res_hi + 32'd1);
      end
    end
    @(negedge clk);
    chk("done_pulse", op_done, 0);
    chk("ready_after", op_ready, 1);
  endtask

  initial begin
    //           op     idx  dly hit pidx hi            res_hi        bad req iwe widx          twe
    vecs[0] = '{2'b00, 6'd0,  0, 1, 6'd7,  32'h0040_2005, 32'h0,        0, 1, 1, 32'h0000_0007, 0};
    vecs[1] = '{2'b00, 6'd0,  2, 0, 6'd9,  32'h7fff_e0aa, 32'h0,        0, 1, 1, 32'h8000_0000, 0};
    vecs[2] = '{2'b01, 6'd3,  1, 0, 6'd0,  32'h0000_2001, 32'h1234_6001, 0, 2, 0, 32'h0,        1};
    vecs[3] = '{2'b01, 6'd40, 0, 0, 6'd0,  32'h0000_2001, 32'h1234_6001, 1, 0, 0, 32'h0,        0};
    vecs[4] = '{2'b10, 6'd17, 0, 0, 6'd0,  32'habcd_e000, 32'h0,        0, 3, 0, 32'h0,        0};
    vecs[5] = '{2'b10, 6'd63, 0, 0, 6'd0,  32'habcd_e000, 32'h0,        1, 0, 0, 32'h0,        0};
    vecs[6] = '{2'b00, 6'd0,  3, 1, 6'd31, 32'h0000_4011, 32'h0,        0, 1, 1, 32'h0000_001f, 0};

    @(negedge clk);
    chk("rst_ready", op_ready, 1);
    chk("rst_random", random, 31);
    chk("rst_outs", {tlb_req, op_done, op_err, wb_index_we, wb_tlb_we}, 0);
    chk("rst_tlb_index", tlb_index, 0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Flush in second REQ cycle abandons TLBWI; later stray tlb_done is ignored.
    @(negedge clk);
    op_valid = 1'b1; op_code = 2'b10; cp0_index = 6'd5;
    @(negedge clk);
    op_valid = 1'b0;
    chk("fl_req1", tlb_req, 3);
    @(negedge clk);
    chk("fl_req2", tlb_req, 3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_req_drop", tlb_req, 0);
    chk("fl_no_done", op_done, 0);
    chk("fl_ready", op_ready, 1);
    tlb_done = 1'b1;
    @(negedge clk);
    tlb_done = 1'b0;
    chk("stray_done", {op_done, wb_index_we, wb_tlb_we, tlb_req}, 0);

    // Random free-run with Wired=4: 30 down to 4, then wraps to 31.
    @(negedge clk);
    cp0_wired_we = 1'b1;
    @(negedge clk);
    cp0_wired_we = 1'b0;
    cp0_wired = 6'd4;
    chk("rand_we", random, 31);
    for (int k = 0; k < 29; k++) begin
      @(negedge clk);
      chk("rand_seq", random, (k < 27) ? 30 - k : ((k == 27) ? 31 : 30));
    end
    cp0_wired_we = 1'b1;
    @(negedge clk);
    cp0_wired_we = 1'b0;
    chk("rand_we_mid", random, 31);
    // TLBWR accepted while Random=30.
    @(negedge clk);
    op_valid = 1'b1; op_code = 2'b11; cp0_index = 6'd2;
    @(negedge clk);
    op_valid = 1'b0;
    chk("wr_req", tlb_req, 4);
    chk("wr_index", tlb_index, 30);
    tlb_done = 1'b1;
    @(negedge clk);
    tlb_done = 1'b0;
    chk("wr_done", {op_done, wb_index_we, wb_tlb_we}, 3'b100);

    // Async reset mid-op.
    @(negedge clk);
    op_valid = 1'b1; op_code = 2'b01; cp0_index = 6'd9;
    @(negedge clk);
    op_valid = 1'b0;
    chk("ar_req", tlb_req, 2);
    #2 rst = 1'b1;
    #1;
    chk("ar_state", {op_ready, tlb_req, op_done}, {1'b1, 3'd0, 1'b0});
    chk("ar_random", random, 31);
    @(negedge clk);
    rst = 1'b0;
    cp0_wired = 6'd31;

`ifdef TLB_OP_WATCHDOG_EN
    @(negedge clk);
    op_valid = 1'b1; op_code = 2'b00;
    @(negedge clk);
    op_valid = 1'b0;
    for (int n = 1; n < 15; n++) @(negedge clk);
    chk("wd_req15", {tlb_req, op_err}, {3'd1, 1'b0});
    @(negedge clk);
    chk("wd_err", op_err, 1);
    chk("wd_ready", op_ready, 1);
    chk("wd_nodone", {op_done, wb_index_we, tlb_req}, 0);
    @(negedge clk);
    chk("wd_err_pulse", op_err, 0);
`else
    chk("no_wd_err", op_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
